// File: rtl/vga_gfx_refill_ctrl_if.sv
// Bus bundle for the VGA line-refill controller: the CPU-side peripheral
// request, the muxed peripheral drive, and the memory fetch port.
//
// Fetch handshake: mem_req rises with a stable mem_addr and stays high
// until the cycle in which mem_ack is seen high. mem_data is valid only in
// that ack cycle. mem_req is low on the cycle after the ack. One request
// is outstanding at a time.
interface vga_gfx_refill_ctrl_if;
    logic [5:0]  cpu_address;
    logic [31:0] cpu_data_in;
    logic [1:0]  cpu_data_write_n;
    logic [1:0]  cpu_data_read_n;

    logic [5:0]  gfx_address;
    logic [31:0] gfx_data_in;
    logic [1:0]  gfx_data_write_n;
    logic [1:0]  gfx_data_read_n;

    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    logic [2:0]  dbg_state;

    modport master (
        input  cpu_address, cpu_data_in, cpu_data_write_n, cpu_data_read_n,
        input  mem_ack, mem_data,
        output gfx_address, gfx_data_in, gfx_data_write_n, gfx_data_read_n,
        output mem_req, mem_addr, dbg_state
    );

    modport slave (
        output cpu_address, cpu_data_in, cpu_data_write_n, cpu_data_read_n,
        output mem_ack, mem_data,
        input  gfx_address, gfx_data_in, gfx_data_write_n, gfx_data_read_n,
        input  mem_req, mem_addr, dbg_state
    );
endinterface

// File: rtl/vga_gfx_refill_ctrl.sv
// Line-refill sequencer for the VGA pixel register file. On each enabled
// rising edge of line_irq it clears the interrupt (read of register 1),
// fetches WORDS words from memory and writes them into the pixel registers,
// yielding the peripheral bus to the CPU whenever the CPU is active.
module vga_gfx_refill_ctrl #(
    parameter int WORDS  = 16,
    parameter int WR_GAP = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic [23:0]           cfg_base,
    input  logic [15:0]           cfg_stride,
    input  logic                  frame_start,
    input  logic                  line_irq,
    vga_gfx_refill_ctrl_if.master bus,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam int         GW       = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(WR_GAP - 1);
    localparam logic [3:0] LAST_IDX = 4'(WORDS - 1);

    logic [2:0]    state_q, state_d;
    logic [23:0]   ptr_q, ptr_d;
    logic [23:0]   base_q, base_d;
    logic [3:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          irq_q, irq_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;
    logic          mem_req_q, mem_req_d;
    logic [23:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   word_q, word_d;
    logic [5:0]    ctl_addr_q, ctl_addr_d;
    logic [31:0]   ctl_data_q, ctl_data_d;
    logic [1:0]    ctl_write_n;
    logic [1:0]    ctl_read_n;
    logic          cpu_active;
    logic          trigger;

    assign cpu_active = (bus.cpu_data_write_n != 2'b11) || (bus.cpu_data_read_n != 2'b11);
    assign trigger    = line_irq && !irq_q && cfg_enable;

    // Sequencer: next state, pointer bookkeeping and the controller's bus drive.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        base_d      = base_q;
        idx_d       = idx_q;
        word_d      = word_q;
        ctl_addr_d  = ctl_addr_q;
        ctl_data_d  = ctl_data_q;
        ctl_write_n = 2'b11;
        ctl_read_n  = 2'b11;
        overrun_d   = overrun_q;
        irq_d       = line_irq;

        if (frame_start) begin
            ptr_d = cfg_base;
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    // frame_start in the same cycle takes effect first
                    base_d  = frame_start ? cfg_base : ptr_q;
                    idx_d   = 4'd0;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                if (!cpu_active) begin
                    ctl_addr_d = 6'd1;
                    ctl_read_n = 2'b00;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    if (!cfg_enable) begin
                        // disabled while fetching: the word is dropped
                        state_d = ST_IDLE;
                    end else begin
                        word_d  = bus.mem_data;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (!cpu_active && (gap_q == '0)) begin
                    ctl_addr_d  = {idx_q, 2'b00};
                    ctl_data_d  = word_q;
                    ctl_write_n = 2'b10;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                // data stays on the drive: upper bytes are sampled late
                if (gap_q == '0) begin
                    if (!cfg_enable) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        if (!frame_start) begin
                            ptr_d = base_q + {8'h00, cfg_stride};
                        end
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (frame_start || !cfg_enable) begin
            overrun_d = 1'b0;
        end else if (trigger && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Fetch port and busy flag follow the next state so they are registered outputs.
    always_comb begin
        mem_req_d  = (state_d == ST_FETCH);
        mem_addr_d = mem_addr_q;
        if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
            mem_addr_d = base_d + {18'h0, idx_d, 2'b00};
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Bus mux: the CPU always wins, otherwise the controller's drive goes out.
    always_comb begin
        if (cpu_active) begin
            bus.gfx_address      = bus.cpu_address;
            bus.gfx_data_in      = bus.cpu_data_in;
            bus.gfx_data_write_n = bus.cpu_data_write_n;
            bus.gfx_data_read_n  = bus.cpu_data_read_n;
        end else begin
            bus.gfx_address      = ctl_addr_d;
            bus.gfx_data_in      = ctl_data_d;
            bus.gfx_data_write_n = ctl_write_n;
            bus.gfx_data_read_n  = ctl_read_n;
        end
    end

    // Gap counter reloads on any peripheral write and counts down to zero.
    always_comb begin
        if (bus.gfx_data_write_n != 2'b11) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end else begin
            gap_d = gap_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 24'h0;
            base_q     <= 24'h0;
            idx_q      <= 4'd0;
            gap_q      <= '0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 24'h0;
            word_q     <= 32'h0;
            ctl_addr_q <= 6'h0;
            ctl_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            word_q     <= word_d;
            ctl_addr_q <= ctl_addr_d;
            ctl_data_q <= ctl_data_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.dbg_state = state_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_vga_gfx_refill_ctrl.sv
// Bench for vga_gfx_refill_ctrl: burst-level reference model, random memory
// latency, optional random CPU traffic, and directed corner scenarios.
module tb_vga_gfx_refill_ctrl;

    localparam int WORDS  = 16;
    localparam int WR_GAP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [23:0] cfg_base = 24'h0;
    logic [15:0] cfg_stride = 16'h0;
    logic        frame_start = 1'b0;
    logic        line_irq = 1'b0;
    logic        busy;
    logic        overrun;

    vga_gfx_refill_ctrl_if bus ();

    vga_gfx_refill_ctrl #(.WORDS(WORDS), .WR_GAP(WR_GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_enable  (cfg_enable),
        .cfg_base    (cfg_base),
        .cfg_stride  (cfg_stride),
        .frame_start (frame_start),
        .line_irq    (line_irq),
        .bus         (bus),
        .busy        (busy),
        .overrun     (overrun)
    );

    // clock / reset block
    initial forever #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // reference model: expected controller transactions {wn,rn,addr,data} and fetch addresses
    logic [41:0] exp_q[$];
    logic [23:0] fetch_q[$];
    logic [23:0] m_ptr = 24'h0;
    logic [31:0] salt = 32'h0;

    function automatic logic [31:0] mem_word(input logic [23:0] a, input logic [31:0] s);
        return ({8'h00, a} * 32'h9E3779B1) ^ s;
    endfunction

    task automatic push_burst(input logic [23:0] base, input int n);
        logic [23:0] a;
        exp_q.push_back({2'b11, 2'b00, 6'd1, 32'h0});
        for (int k = 0; k < n; k++) begin
            a = base + 24'(4 * k);
            fetch_q.push_back(a);
            exp_q.push_back({2'b10, 2'b11, 6'(k * 4), mem_word(a, salt)});
        end
    endtask

    // memory responder
    int mem_delay_max = 0;
    bit mem_fixed = 1'b0;
    int mem_cnt = -1;

    initial begin
        bus.mem_ack  = 1'b0;
        bus.mem_data = 32'h0;
        forever begin
            @(posedge clk);
            #3;
            if (!bus.mem_req) begin
                bus.mem_ack  = 1'b0;
                bus.mem_data = $urandom;
                mem_cnt      = -1;
            end else begin
                if (mem_cnt < 0) begin
                    mem_cnt = mem_fixed ? mem_delay_max : int'($urandom_range(0, mem_delay_max));
                end
                if (mem_cnt == 0) begin
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = mem_word(bus.mem_addr, salt);
                end else begin
                    bus.mem_ack  = 1'b0;
                    bus.mem_data = $urandom;
                    mem_cnt--;
                end
            end
        end
    end

    // CPU driver: directed command or random background traffic
    bit          noise_on = 1'b0;
    bit          cmd_valid = 1'b0;
    logic [1:0]  cmd_wn = 2'b11;
    logic [1:0]  cmd_rn = 2'b11;
    logic [5:0]  cmd_addr = 6'h0;
    logic [31:0] cmd_data = 32'h0;

    initial begin
        bus.cpu_address      = 6'h0;
        bus.cpu_data_in      = 32'h0;
        bus.cpu_data_write_n = 2'b11;
        bus.cpu_data_read_n  = 2'b11;
        forever begin
            @(posedge clk);
            #2;
            if (cmd_valid) begin
                bus.cpu_address      = cmd_addr;
                bus.cpu_data_in      = cmd_data;
                bus.cpu_data_write_n = cmd_wn;
                bus.cpu_data_read_n  = cmd_rn;
            end else if (noise_on && ($urandom_range(0, 99) < 12)) begin
                bus.cpu_address = 6'($urandom);
                bus.cpu_data_in = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    bus.cpu_data_write_n = 2'($urandom_range(0, 2));
                    bus.cpu_data_read_n  = 2'b11;
                end else begin
                    bus.cpu_data_write_n = 2'b11;
                    bus.cpu_data_read_n  = 2'($urandom_range(0, 2));
                end
            end else begin
                bus.cpu_data_write_n = 2'b11;
                bus.cpu_data_read_n  = 2'b11;
            end
        end
    end

    // monitor / scoreboard, sampled on the falling edge
    int          cyc = 0;
    int          last_wr_cyc = -100;
    int          ctl_wr_count = 0;
    logic [5:0]  last_wr_addr = 6'h0;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [23:0] prev_addr = 24'h0;
    bit          have_data = 1'b0;
    logic [31:0] last_data = 32'h0;
    int          req_len = 0;

    initial begin
        logic        cpu_act;
        logic [41:0] obs;
        logic [41:0] exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                last_wr_cyc = cyc - 100;
                prev_req    = 1'b0;
                prev_ack    = 1'b0;
                have_data   = 1'b0;
                req_len     = 0;
            end else begin
                cpu_act = (bus.cpu_data_write_n != 2'b11) || (bus.cpu_data_read_n != 2'b11);
                if (cpu_act) begin
                    check("cpu_pass",
                          {bus.gfx_address, bus.gfx_data_in, bus.gfx_data_write_n, bus.gfx_data_read_n},
                          {bus.cpu_address, bus.cpu_data_in, bus.cpu_data_write_n, bus.cpu_data_read_n});
                end else if ((bus.gfx_data_write_n != 2'b11) || (bus.gfx_data_read_n != 2'b11)) begin
                    obs = {bus.gfx_data_write_n, bus.gfx_data_read_n, bus.gfx_address,
                           (bus.gfx_data_write_n != 2'b11) ? bus.gfx_data_in : 32'h0};
                    if (exp_q.size() == 0) begin
                        check("ctl_txn_extra", 1, 0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("ctl_txn", obs, exp);
                    end
                    if (bus.gfx_data_write_n != 2'b11) begin
                        check("wr_spacing", ((cyc - last_wr_cyc) >= WR_GAP), 1);
                        last_data    = bus.gfx_data_in;
                        have_data    = 1'b1;
                        last_wr_addr = bus.gfx_address;
                        ctl_wr_count++;
                    end
                end else if (have_data) begin
                    check("data_hold", bus.gfx_data_in, last_data);
                end
                if (bus.gfx_data_write_n != 2'b11) begin
                    last_wr_cyc = cyc;
                end

                if (prev_req && !prev_ack) begin
                    check("req_hold", {bus.mem_req, bus.mem_addr}, {1'b1, prev_addr});
                end
                if (prev_req && prev_ack) begin
                    check("req_drop", bus.mem_req, 0);
                end
                if (bus.mem_req && !(prev_req && !prev_ack)) begin
                    req_len = 0;
                    if (fetch_q.size() == 0) begin
                        check("fetch_extra", 1, 0);
                    end else begin
                        check("fetch_addr", bus.mem_addr, fetch_q.pop_front());
                    end
                end
                if (bus.mem_req) begin
                    req_len++;
                end
                if (bus.mem_req && bus.mem_ack && mem_fixed) begin
                    check("req_len", req_len, mem_delay_max + 1);
                end
                prev_req  = bus.mem_req;
                prev_ack  = bus.mem_ack;
                prev_addr = bus.mem_addr;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_ptr = cfg_base;
    endtask

    task automatic pulse_irq(input bit with_frame);
        tick();
        line_irq    = 1'b1;
        frame_start = with_frame;
        tick();
        line_irq    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic start_burst(input bit with_frame, input int n);
        if (with_frame) m_ptr = cfg_base;
        salt = $urandom;
        push_burst(m_ptr, n);
        pulse_irq(with_frame);
        check("busy_set", busy, 1);
    endtask

    task automatic finish_burst(input bit full);
        for (int i = 0; i < 4000; i++) begin
            if (!busy) break;
            tick();
        end
        check("burst_end", busy, 0);
        check("txn_left", exp_q.size(), 0);
        check("fetch_left", fetch_q.size(), 0);
        if (full) m_ptr = m_ptr + {8'h00, cfg_stride};
    endtask

    task automatic wait_wr(input logic [5:0] a);
        int c0;
        bit hit;
        c0  = ctl_wr_count;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if ((ctl_wr_count != c0) && (last_wr_addr == a)) begin
                hit = 1'b1;
                break;
            end
        end
        check("wait_wr", hit, 1);
    endtask

    // main stimulus
    initial begin
        bit hit;
        logic [23:0] b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_gfx_rw", {bus.gfx_data_write_n, bus.gfx_data_read_n}, 4'hF);
        rst_n = 1'b1;
        tick();
        m_ptr = 24'h0;

        // basic refill, then the next line continues at base + stride
        cfg_enable    = 1'b1;
        cfg_base      = 24'h001000;
        cfg_stride    = 16'h0040;
        mem_delay_max = 2;
        do_frame();
        start_burst(1'b0, WORDS);
        finish_burst(1'b1);
        start_burst(1'b0, WORDS);
        finish_burst(1'b1);

        // CPU write lands exactly when the controller write for word 2 is due
        mem_fixed     = 1'b1;
        mem_delay_max = 0;
        start_burst(1'b0, WORDS);
        wait_wr(6'd4);
        repeat (9) @(posedge clk);
        #1;
        cmd_addr  = 6'd5;
        cmd_data  = 32'hA5A5_5A5A;
        cmd_wn    = 2'b00;
        cmd_rn    = 2'b11;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        finish_burst(1'b1);

        // slow memory
        mem_delay_max = 5;
        start_burst(1'b0, WORDS);
        finish_burst(1'b1);

        // overrun: second trigger mid-burst is ignored
        mem_fixed     = 1'b0;
        mem_delay_max = 3;
        start_burst(1'b0, WORDS);
        wait_wr(6'd0);
        pulse_irq(1'b0);
        check("overrun_set", overrun, 1);
        finish_burst(1'b1);
        check("overrun_sticky", overrun, 1);
        cfg_base = 24'h0A0000;
        do_frame();
        check("overrun_clr", overrun, 0);
        start_burst(1'b0, WORDS);
        finish_burst(1'b1);

        // disable during the gap after word 3, then restart at the same base
        b = m_ptr;
        start_burst(1'b0, 4);
        wait_wr(6'd12);
        cfg_enable = 1'b0;
        finish_burst(1'b0);
        check("ptr_kept", m_ptr, b);
        cfg_enable = 1'b1;
        tick();
        start_burst(1'b0, WORDS);
        finish_burst(1'b1);

        // random bases/strides with CPU traffic, including address wrap
        noise_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cfg_base      = (i == 0) ? 24'hFFFFF0 : 24'($urandom);
            cfg_stride    = 16'($urandom);
            mem_delay_max = int'($urandom_range(0, 4));
            if ((i % 2) == 1) begin
                start_burst(1'b1, WORDS);
            end else begin
                do_frame();
                start_burst(1'b0, WORDS);
            end
            finish_burst(1'b1);
            start_burst(1'b0, WORDS);
            finish_burst(1'b1);
        end
        noise_on = 1'b0;
        tick();

        // reset while a fetch is pending
        mem_fixed     = 1'b1;
        mem_delay_max = 30;
        start_burst(1'b0, WORDS);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.mem_req) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("reset_req_seen", hit, 1);
        tick();
        cmd_addr  = 6'd9;
        cmd_data  = 32'h1234_5678;
        cmd_wn    = 2'b10;
        cmd_rn    = 2'b11;
        cmd_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", bus.mem_req, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pass", {bus.gfx_address, bus.gfx_data_in, bus.gfx_data_write_n, bus.gfx_data_read_n},
              {6'd9, 32'h1234_5678, 2'b10, 2'b11});
        tick();
        cmd_valid = 1'b0;
        exp_q.delete();
        fetch_q.delete();
        tick();
        rst_n = 1'b1;
        m_ptr = 24'h0;
        tick();

        // after reset the pointer restarts at zero
        mem_fixed     = 1'b0;
        mem_delay_max = 1;
        start_burst(1'b0, WORDS);
        finish_burst(1'b1);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
